inert_intf: RTL and testbench
=============================

// Module: inert_intf
// PURPOSE
//  IMU front end for the balance datapath. After power-up it configures the inertial sensor over SPI.
//  On each data-ready interrupt it reads the pitch-rate and AZ registers as byte pairs.
//  It presents them as 16-bit signed words with a 1-cycle vld strobe to the pitch integrator.
//  It drives an SPI monarch through a wrt/done handshake and owns no SPI pins itself.
// PARAMETERS
//  TMR_W     16    width of power-up settle timer; init starts when timer saturates (all ones)
//  TMO_CYC   4096  cycles to wait for done before aborting a transaction (INERT_TIMEOUT_EN only)
// PORTS
//  clk       in   1   system clock
//  rst_n     in   1   asynchronous active-low reset
//  INT       in   1   IMU data-ready interrupt, asynchronous, active high
//  done      in   1   SPI monarch transaction complete, 1-cycle pulse
//  rd_data   in   16  SPI monarch read data; byte of interest in [7:0]
//  wrt       out  1   start SPI transaction, 1-cycle pulse
//  cmd       out  16  SPI command word, valid while wrt high, held until done
//  vld       out  1   new ptch_rt/AZ pair available, 1-cycle pulse
//  ptch_rt   out  16  signed gyro pitch rate, registered
//  AZ        out  16  signed Z accel, registered
//  err       out  1   transaction timeout pulse (tied 0 without INERT_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset: wrt=0, cmd=0, vld=0, ptch_rt=0, AZ=0, err=0, timer=0, state=SETTLE. A mid-operation reset abandons the transaction and reruns init.
//  - INT passes through 2 flops before use; raw INT is never sampled directly.
//  - States: SETTLE, INIT0..INIT3, WAIT_INT, RD_PRL, RD_PRH, RD_AZL, RD_AZH, UPDATE.
//  - SETTLE: timer increments each clk. At all-ones, pulse wrt with cmd=16'h0D02 and enter INIT0.
//  - INITn: hold cmd and wait for done. On done, pulse wrt with the next word and advance.
//    Init words in order: 0D02 (INT on data ready), 1053 (accel 208Hz), 1150 (gyro 208Hz), 1460 (rounding).
//  - Done of INIT3 goes to WAIT_INT; no wrt is issued. Init runs exactly once per reset.
//  - WAIT_INT: synced INT==1 -> pulse wrt with cmd=16'hA2xx, enter RD_PRL. INT is level-sensitive.
//  - Read commands, low byte don't-care (driven 00): A2 pitch-rate L, A3 pitch-rate H, AC AZ L, AD AZ H.
//  - Each RD_* state captures rd_data[7:0] into a holding register on done, then pulses wrt for the next read.
//  - After RD_AZH done, go to UPDATE. UPDATE writes ptch_rt={PRH,PRL} and AZ={AZH,AZL} in the same clock and pulses vld.
//  - UPDATE->WAIT_INT is unconditional. Outputs change only in UPDATE, so a pair is never torn.
//  - Latency: vld is high exactly 1 cycle after the done that returns AZH.
//  - Back-to-back: if INT is still high in WAIT_INT, the next read starts on that cycle. Minimum gap between vld pulses is 4 transactions + 2 cycles.
//  - done outside a waiting state is ignored. wrt never asserts while a transaction is outstanding.
//  - cmd holds its last value between transactions.
// CONFIGURATION
//  INERT_TIMEOUT_EN defined:
//  - A counter clears on each wrt and counts while awaiting done.
//  - At TMO_CYC it pulses err for 1 cycle and discards partial bytes; vld is not pulsed.
//  - In INITn it restarts the same init word. In RD_* it returns to WAIT_INT.
//  INERT_TIMEOUT_EN undefined: no counter, err tied 0, the block waits for done indefinitely.
// TESTING (bench overrides TMR_W=4)
//  1. Reset, SPI model returns done 10 cycles after each wrt -> wrt fires at timer=15.
//     cmd sequence 0D02,1053,1150,1460. No wrt afterwards while INT=0.
//  2. Pulse INT high. Model returns bytes 34,12,CD,AB -> cmds A2xx,A3xx,ACxx,ADxx in order.
//     Then vld=1 for 1 cycle with ptch_rt=16'h1234 and AZ=16'hABCD, 1 cycle after the 4th done.
//  3. Bytes 00,80,FF,FF -> ptch_rt=16'h8000 (-32768), AZ=16'hFFFF (-1). Outputs hold until the next vld.
//  4. Hold INT high continuously -> consecutive read bursts, each vld 1 cycle. Outputs never change off a vld cycle.
//  5. Assert rst_n low between the 2nd and 3rd read done.
//     -> All outputs 0 immediately, no vld. Full settle and init repeat after release.
//  6. [INERT_TIMEOUT_EN, TMO_CYC=32] Model drops done on the AZL read.
//     -> err pulses 32 cycles after that wrt, no vld, state returns to WAIT_INT.
//     The next INT completes normally.

Source files
------------

// File: rtl/inert_intf.sv
// IMU front end: power-up settle, four-word SPI init, then per-interrupt pitch-rate/AZ byte-pair reads.
// Optional transaction timeout enabled by defining INERT_TIMEOUT_EN.
module inert_intf #(
  parameter int TMR_W   = 16,
  parameter int TMO_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        err
);

  typedef enum logic [3:0] {
    S_SETTLE, S_INIT0, S_INIT1, S_INIT2, S_INIT3, S_WAIT_INT,
    S_RD_PRL, S_RD_PRH, S_RD_AZL, S_RD_AZH, S_UPDATE
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               int_meta_q, int_sync_q;
  logic               wrt_q, wrt_d;
  logic [15:0]        cmd_q, cmd_d;
  logic               vld_q, vld_d;
  logic [15:0]        ptch_q, ptch_d;
  logic [15:0]        az_q, az_d;
  logic [7:0]         prl_q, prl_d, prh_q, prh_d, azl_q, azl_d;
  logic               err_d;
  logic               unused_rd_hi;

  assign unused_rd_hi = &{1'b0, rd_data[15:8]};

  // Two-flop synchronizer: raw INT is never looked at by the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_meta_q <= 1'b0;
      int_sync_q <= 1'b0;
    end else begin
      int_meta_q <= INT;
      int_sync_q <= int_meta_q;
    end
  end

`ifdef INERT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q;
  logic             awaiting;

  assign awaiting = state_q inside {S_INIT0, S_INIT1, S_INIT2, S_INIT3,
                                    S_RD_PRL, S_RD_PRH, S_RD_AZL, S_RD_AZH};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  logic [31:0] unused_tmo_cyc;
  assign unused_tmo_cyc = 32'(TMO_CYC);
  assign err = 1'b0;
`endif

  // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    vld_d   = 1'b0;
    ptch_d  = ptch_q;
    az_d    = az_q;
    prl_d   = prl_q;
    prh_d   = prh_q;
    azl_d   = azl_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_SETTLE: begin
        if (&timer_q) begin
          wrt_d   = 1'b1;
          cmd_d   = 16'h0D02;
          state_d = S_INIT0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_INIT0: if (done) begin wrt_d = 1'b1; cmd_d = 16'h1053; state_d = S_INIT1; end
      S_INIT1: if (done) begin wrt_d = 1'b1; cmd_d = 16'h1150; state_d = S_INIT2; end
      S_INIT2: if (done) begin wrt_d = 1'b1; cmd_d = 16'h1460; state_d = S_INIT3; end
      S_INIT3: if (done) state_d = S_WAIT_INT;
      S_WAIT_INT: begin
        if (int_sync_q) begin
          wrt_d   = 1'b1;
          cmd_d   = 16'hA200;
          state_d = S_RD_PRL;
        end
      end
      S_RD_PRL: if (done) begin prl_d = rd_data[7:0]; wrt_d = 1'b1; cmd_d = 16'hA300; state_d = S_RD_PRH; end
      S_RD_PRH: if (done) begin prh_d = rd_data[7:0]; wrt_d = 1'b1; cmd_d = 16'hAC00; state_d = S_RD_AZL; end
      S_RD_AZL: if (done) begin azl_d = rd_data[7:0]; wrt_d = 1'b1; cmd_d = 16'hAD00; state_d = S_RD_AZH; end
      S_RD_AZH: begin
        // Both words load together on the edge into UPDATE, so vld and the new pair
        // appear in the cycle right after the AZH done and a pair is never torn.
        if (done) begin
          ptch_d  = {prh_q, prl_q};
          az_d    = {rd_data[7:0], azl_q};
          vld_d   = 1'b1;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: state_d = S_WAIT_INT;
      default:  state_d = S_SETTLE;
    endcase

`ifdef INERT_TIMEOUT_EN
    tmo_d = tmo_q;
    if (wrt_d) begin
      tmo_d = '0;
    end else if (awaiting && !done) begin
      if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
        err_d = 1'b1;
        tmo_d = '0;
        if (state_q inside {S_INIT0, S_INIT1, S_INIT2, S_INIT3}) begin
          wrt_d = 1'b1;  // cmd_q still holds the init word being retried
        end else begin
          state_d = S_WAIT_INT;
          prl_d   = '0;
          prh_d   = '0;
          azl_d   = '0;
        end
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the byte holding registers are reset too; they are a handful of flops, not a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SETTLE;
      timer_q <= '0;
      wrt_q   <= 1'b0;
      cmd_q   <= '0;
      vld_q   <= 1'b0;
      ptch_q  <= '0;
      az_q    <= '0;
      prl_q   <= '0;
      prh_q   <= '0;
      azl_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      wrt_q   <= wrt_d;
      cmd_q   <= cmd_d;
      vld_q   <= vld_d;
      ptch_q  <= ptch_d;
      az_q    <= az_d;
      prl_q   <= prl_d;
      prh_q   <= prh_d;
      azl_q   <= azl_d;
    end
  end

  assign wrt     = wrt_q;
  assign cmd     = cmd_q;
  assign vld     = vld_q;
  assign ptch_rt = ptch_q;
  assign AZ      = az_q;

endmodule

// File: tb/tb_inert_intf.sv
// Bench for inert_intf: SPI responder model plus scoreboard of expected commands and output pairs.
// Define INERT_TIMEOUT_EN for both files to exercise the timeout sequence.
module tb_inert_intf;

  localparam int TMR_W   = 4;
  localparam int TMO_CYC = 32;

  logic        clk, rst_n, INT, done, wrt, vld, err;
  logic [15:0] rd_data, cmd, ptch_rt, AZ;

  inert_intf #(.TMR_W(TMR_W), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .vld(vld), .ptch_rt(ptch_rt), .AZ(AZ), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  b0, b1, b2, b3;
    logic [15:0] pr, az;
  } vec_t;

  vec_t vecs [6];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues and responder state
  logic [15:0] exp_cmd_q [$];
  logic [7:0]  byte_q    [$];
  logic [31:0] exp_pair_q[$];

  int          cyc = 0;
  int          pend = 0;
  logic [15:0] pend_cmd;
  logic [7:0]  pend_byte;
  int          azh_done_cyc = -100;
  int          wrt_ac_cyc = -100;
  int          last_vld_cyc = -1;
  int          gap = 0;
  int          vld_count = 0, a2_count = 0, rd_done_count = 0, err_count = 0;
  logic        vld_prev = 1'b0, err_prev = 1'b0;
  logic [15:0] prev_pr = '0, prev_az = '0;
  bit          drop_azl = 1'b0, expect_err = 1'b0;

  // Monitor first, then drive done/rd_data, all on the falling edge.
  initial begin
    done    = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pend     = 0;
        done     = 1'b0;
        vld_prev = 1'b0;
        err_prev = 1'b0;
        prev_pr  = ptch_rt;
        prev_az  = AZ;
      end else begin
        if (vld) begin
          if (vld_prev) check("vld_width", vld & vld_prev, 1'b0);
          if (exp_pair_q.size() == 0) begin
            check("vld_spurious", vld, 1'b0);
          end else begin
            logic [31:0] e;
            e = exp_pair_q.pop_front();
            check("ptch_rt", ptch_rt, e[31:16]);
            check("AZ", AZ, e[15:0]);
          end
          check("vld_latency", cyc - azh_done_cyc, 1);
          if (last_vld_cyc >= 0) gap = cyc - last_vld_cyc;
          last_vld_cyc = cyc;
          vld_count++;
        end else begin
          check("hold", {ptch_rt, AZ}, {prev_pr, prev_az});
        end
        if (err) begin
          if (!expect_err) check("err_spurious", err, 1'b0);
          else             check("err_latency", cyc - wrt_ac_cyc, TMO_CYC);
          if (err_prev) check("err_width", err & err_prev, 1'b0);
          err_count++;
        end
        if (wrt) check("wrt_busy", pend != 0, 1'b0);
        // responder: done exactly 10 cycles after the wrt was seen
        done = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            done    = 1'b1;
            rd_data = {8'hEE, pend_byte};
            if (pend_cmd[15:8] inside {8'hA2, 8'hA3, 8'hAC, 8'hAD}) rd_done_count++;
            if (pend_cmd[15:8] == 8'hAD) azh_done_cyc = cyc;
          end
        end
        if (wrt) begin
          if (exp_cmd_q.size() == 0) check("wrt_spurious", wrt, 1'b0);
          else                       check("cmd", cmd, exp_cmd_q.pop_front());
          pend      = 10;
          pend_cmd  = cmd;
          pend_byte = 8'h00;
          if (cmd[15:8] inside {8'hA2, 8'hA3, 8'hAC, 8'hAD} && byte_q.size() > 0)
            pend_byte = byte_q.pop_front();
          if (cmd[15:8] == 8'hA2) a2_count++;
          if (cmd[15:8] == 8'hAC) begin
            wrt_ac_cyc = cyc;
            if (drop_azl) pend = 0;
          end
        end
        vld_prev = vld;
        err_prev = err;
        prev_pr  = ptch_rt;
        prev_az  = AZ;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wrt"}, wrt, 1'b0);
    check({tag, "_cmd"}, cmd, 16'h0000);
    check({tag, "_vld"}, vld, 1'b0);
    check({tag, "_ptch"}, ptch_rt, 16'h0000);
    check({tag, "_AZ"}, AZ, 16'h0000);
    check({tag, "_err"}, err, 1'b0);
  endtask

  task automatic do_init();
    int n;
    exp_cmd_q.push_back(16'h0D02);
    exp_cmd_q.push_back(16'h1053);
    exp_cmd_q.push_back(16'h1150);
    exp_cmd_q.push_back(16'h1460);
    @(negedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!wrt && n < 40);
    check("settle_cycles", n, 16);
    repeat (70) @(negedge clk);
    check("init_cmds_left", exp_cmd_q.size(), 0);
    check("cmd_after_init", cmd, 16'h1460);
  endtask

  task automatic push_burst(input int idx, input bit expect_pair);
    exp_cmd_q.push_back(16'hA200);
    exp_cmd_q.push_back(16'hA300);
    exp_cmd_q.push_back(16'hAC00);
    exp_cmd_q.push_back(16'hAD00);
    byte_q.push_back(vecs[idx].b0);
    byte_q.push_back(vecs[idx].b1);
    byte_q.push_back(vecs[idx].b2);
    byte_q.push_back(vecs[idx].b3);
    if (expect_pair) exp_pair_q.push_back({vecs[idx].pr, vecs[idx].az});
  endtask

  task automatic wait_vld(input int target, input int budget);
    int n;
    n = 0;
    while (vld_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("vld_count", vld_count, target);
  endtask

  task automatic pulse_int();
    @(negedge clk);
    INT = 1'b1;
    repeat (3) @(negedge clk);
    INT = 1'b0;
  endtask

  task automatic run_burst(input int idx);
    int target;
    target = vld_count + 1;
    push_burst(idx, 1'b1);
    pulse_int();
    wait_vld(target, 120);
  endtask

  initial begin
    int base, n;
    vecs[0] = '{b0: 8'h34, b1: 8'h12, b2: 8'hCD, b3: 8'hAB, pr: 16'h1234, az: 16'hABCD};
    vecs[1] = '{b0: 8'h00, b1: 8'h80, b2: 8'hFF, b3: 8'hFF, pr: 16'h8000, az: 16'hFFFF};
    vecs[2] = '{b0: 8'h7F, b1: 8'h00, b2: 8'h01, b3: 8'h80, pr: 16'h007F, az: 16'h8001};
    vecs[3] = '{b0: 8'hFF, b1: 8'h7F, b2: 8'h00, b3: 8'h00, pr: 16'h7FFF, az: 16'h0000};
    vecs[4] = '{b0: 8'h5A, b1: 8'hC3, b2: 8'h3C, b3: 8'h11, pr: 16'hC35A, az: 16'h113C};
    vecs[5] = '{b0: 8'h01, b1: 8'h02, b2: 8'h03, b3: 8'h04, pr: 16'h0201, az: 16'h0403};
    rst_n = 1'b0;
    INT   = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");

    // Settle then init sequence; no traffic with INT low.
    do_init();

    // Table-driven single bursts.
    for (int i = 0; i < 4; i++) begin
      run_burst(i);
      if (i == 1) begin
        repeat (20) @(negedge clk);
        check("hold_ptch", ptch_rt, 16'h8000);
        check("hold_AZ", AZ, 16'hFFFF);
        check("cmd_hold", cmd, 16'hAD00);
      end
    end

    // Back-to-back bursts with INT held high.
    base = a2_count;
    n = vld_count;
    for (int i = 4; i < 6; i++) push_burst(i, 1'b1);
    push_burst(0, 1'b1);
    @(negedge clk);
    INT = 1'b1;
    for (int k = 0; k < 300 && a2_count < base + 3; k++) @(negedge clk);
    INT = 1'b0;
    check("b2b_starts", a2_count, base + 3);
    wait_vld(n + 3, 200);
    check("b2b_gap", gap, 46);

    // Reset between the 2nd and 3rd read done.
    base = rd_done_count;
    exp_cmd_q.push_back(16'hA200);
    exp_cmd_q.push_back(16'hA300);
    exp_cmd_q.push_back(16'hAC00);
    byte_q.push_back(8'h11);
    byte_q.push_back(8'h22);
    byte_q.push_back(8'h33);
    pulse_int();
    for (int k = 0; k < 100 && rd_done_count < base + 2; k++) @(negedge clk);
    check("rd_done_before_rst", rd_done_count, base + 2);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    check("midrst_cmds_left", exp_cmd_q.size(), 0);
    byte_q.delete();
    n = vld_count;
    repeat (3) @(negedge clk);
    do_init();
    check("no_vld_after_rst", vld_count, n);
    run_burst(5);

`ifdef INERT_TIMEOUT_EN
    // AZL done is dropped: err after TMO_CYC, no vld, then a normal read.
    n = vld_count;
    base = err_count;
    expect_err = 1'b1;
    drop_azl   = 1'b1;
    exp_cmd_q.push_back(16'hA200);
    exp_cmd_q.push_back(16'hA300);
    exp_cmd_q.push_back(16'hAC00);
    byte_q.push_back(8'h99);
    byte_q.push_back(8'h88);
    byte_q.push_back(8'h77);
    pulse_int();
    for (int k = 0; k < 150 && err_count < base + 1; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("tmo_err_count", err_count, base + 1);
    check("tmo_no_vld", vld_count, n);
    drop_azl   = 1'b0;
    expect_err = 1'b0;
    byte_q.delete();
    run_burst(2);
`endif

    repeat (10) @(negedge clk);
    check("cmds_left", exp_cmd_q.size(), 0);
    check("pairs_left", exp_pair_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

endmodule
